im_access_arbiter: RTL and testbench

//  Shares one single-port synchronous instruction RAM (4096 words, base 0x0000_3000) between the F-stage

---
 rtl/im_access_arbiter_if.sv | 38 +++
 rtl/im_access_arbiter.sv | 79 +++++++
 tb/tb_im_access_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/im_access_arbiter_if.sv
// Fetch, loader and IM RAM signals shared by the instruction-memory access arbiter.
// The arbiter takes the slave modport; the environment (F stage, loader, RAM) takes master.
interface im_access_arbiter_if #(parameter int AW = 12);
    logic          f_req;
    logic [31:0]   f_pc;
    logic          f_gnt;
    logic          f_stall;
    logic          f_valid;
    logic [31:0]   f_instr;
    logic          f_fault;
    logic          ld_req;
    logic          ld_we;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [31:0]   ld_rdata;
    logic          ld_fault;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  f_req, f_pc, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        output f_gnt, f_stall, f_valid, f_instr, f_fault,
               ld_gnt, ld_rvalid, ld_rdata, ld_fault,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_pc, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        input  f_gnt, f_stall, f_valid, f_instr, f_fault,
               ld_gnt, ld_rvalid, ld_rdata, ld_fault,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/im_access_arbiter.sv
// Shares one single-port IM RAM between the F-stage fetch port and the loader/debug port.
// One grant per cycle, byte->word translation, range/alignment faults, data one cycle after grant.
module im_access_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          MAX_LD_RUN = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    im_access_arbiter_if.slave   bus
);
    localparam logic [31:0] SPAN = 32'd4 << DEPTH_LOG2;
    localparam int          RW   = $clog2(MAX_LD_RUN + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LDRD, OWN_LDWR} owner_e;

    owner_e        owner_q, owner_d;
    logic [RW-1:0] ld_run_q;
    logic          f_valid_q, f_fault_q, ld_rvalid_q, ld_fault_q;

    logic [31:0] f_off, ld_off, sel_off;
    logic        f_ok, ld_ok, sel_ok;
    logic        ld_win, f_win, fault_d;

    always_comb begin
        f_off  = bus.f_pc - BASE_ADDR;
        ld_off = bus.ld_addr - BASE_ADDR;
        f_ok   = (f_off < SPAN) && (f_off[1:0] == 2'b00);
        ld_ok  = (ld_off < SPAN) && (ld_off[1:0] == 2'b00);
        // Loader yields once it has taken MAX_LD_RUN grants in a row over a waiting fetch
        ld_win = bus.ld_req && (!bus.f_req || (ld_run_q < RW'(MAX_LD_RUN)));
        f_win  = bus.f_req && !ld_win;
        sel_off = ld_win ? ld_off : f_off;
        sel_ok  = ld_win ? ld_ok  : f_ok;
        fault_d = (ld_win || f_win) && !sel_ok;

        owner_d = OWN_NONE;
        if (ld_win)     owner_d = bus.ld_we ? OWN_LDWR : OWN_LDRD;
        else if (f_win) owner_d = OWN_FETCH;
    end

    assign bus.f_gnt     = f_win;
    assign bus.ld_gnt    = ld_win;
    assign bus.f_stall   = bus.f_req && !f_win;
    assign bus.mem_en    = (ld_win || f_win) && sel_ok;
    assign bus.mem_we    = bus.mem_en && ld_win && bus.ld_we;
    assign bus.mem_addr  = sel_off[DEPTH_LOG2+1:2];
    assign bus.mem_wdata = ld_win ? bus.ld_wdata : 32'h0;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            owner_q     <= OWN_NONE;
            ld_run_q    <= '0;
            f_valid_q   <= 1'b0;
            f_fault_q   <= 1'b0;
            ld_rvalid_q <= 1'b0;
            ld_fault_q  <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            f_valid_q   <= (owner_d == OWN_FETCH);
            f_fault_q   <= (owner_d == OWN_FETCH) && fault_d;
            ld_rvalid_q <= (owner_d == OWN_LDRD);
            ld_fault_q  <= ((owner_d == OWN_LDRD) || (owner_d == OWN_LDWR)) && fault_d;
            // Any cycle that is not a loader grant over a pending fetch ends the run
            if (ld_win && bus.f_req) begin
                if (ld_run_q != RW'(MAX_LD_RUN)) ld_run_q <= ld_run_q + 1'b1;
            end else begin
                ld_run_q <= '0;
            end
        end
    end

    assign bus.f_valid   = f_valid_q;
    assign bus.f_fault   = f_fault_q;
    assign bus.ld_rvalid = ld_rvalid_q;
    assign bus.ld_fault  = ld_fault_q;
    assign bus.f_instr   = (owner_q == OWN_FETCH && !f_fault_q) ? bus.mem_rdata : 32'h0;
    assign bus.ld_rdata  = (owner_q == OWN_LDRD && !ld_fault_q) ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_im_access_arbiter.sv
// Directed bench for im_access_arbiter with a behavioural synchronous IM RAM.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_im_access_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cmps = 0;
    int   errs = 0;

    im_access_arbiter_if #(.AW(12)) bus();

    im_access_arbiter #(
        .BASE_ADDR(32'h0000_3000), .DEPTH_LOG2(12), .MAX_LD_RUN(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [4096];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    task automatic idle();
        bus.f_req = 1'b0; bus.f_pc = 32'h0;
        bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = 32'h0; bus.ld_wdata = 32'h0;
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        idle();
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = a; bus.ld_wdata = d;
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmps++; if (bus.f_valid !== 1'b0)   begin errs++; $display("FAIL reset_f_valid got %b exp 0", bus.f_valid); end
        cmps++; if (bus.ld_rvalid !== 1'b0) begin errs++; $display("FAIL reset_ld_rvalid got %b exp 0", bus.ld_rvalid); end
        cmps++; if (bus.f_fault !== 1'b0 || bus.ld_fault !== 1'b0)
            begin errs++; $display("FAIL reset_faults got %b%b exp 00", bus.f_fault, bus.ld_fault); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        cmps++; if (bus.mem_en !== 1'b0) begin errs++; $display("FAIL idle_mem_en got %b exp 0", bus.mem_en); end
        @(negedge clk); #1;
        cmps++; if (bus.f_valid !== 1'b0 || bus.ld_rvalid !== 1'b0)
            begin errs++; $display("FAIL idle_no_valid got %b%b exp 00", bus.f_valid, bus.ld_rvalid); end
    endtask

    task automatic test_fetch();
        ld_write(32'h3000, 32'h1111_1111);
        ld_write(32'h3004, 32'h2222_2222);
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_pc = 32'h3000;
        #1;
        cmps++; if (bus.mem_addr !== 12'h000 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0)
            begin errs++; $display("FAIL fetch0_mem got addr=%h en=%b we=%b exp 000/1/0", bus.mem_addr, bus.mem_en, bus.mem_we); end
        cmps++; if (bus.f_gnt !== 1'b1 || bus.f_stall !== 1'b0)
            begin errs++; $display("FAIL fetch0_gnt got gnt=%b stall=%b exp 1/0", bus.f_gnt, bus.f_stall); end
        @(negedge clk);
        bus.f_pc = 32'h3004;
        #1;
        cmps++; if (bus.mem_addr !== 12'h001) begin errs++; $display("FAIL fetch1_addr got %h exp 001", bus.mem_addr); end
        cmps++; if (bus.f_valid !== 1'b1 || bus.f_instr !== 32'h1111_1111)
            begin errs++; $display("FAIL fetch0_data got v=%b %h exp 1 11111111", bus.f_valid, bus.f_instr); end
        @(negedge clk);
        idle();
        #1;
        cmps++; if (bus.f_valid !== 1'b1 || bus.f_instr !== 32'h2222_2222 || bus.f_fault !== 1'b0)
            begin errs++; $display("FAIL fetch1_data got v=%b %h f=%b exp 1 22222222 0", bus.f_valid, bus.f_instr, bus.f_fault); end
        @(negedge clk); #1;
        cmps++; if (bus.f_valid !== 1'b0) begin errs++; $display("FAIL fetch_idle_valid got %b exp 0", bus.f_valid); end
    endtask

    task automatic test_write_fetch();
        @(negedge clk);
        idle();
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h3008; bus.ld_wdata = 32'hDEAD_BEEF;
        #1;
        cmps++; if (bus.ld_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h002 || bus.mem_wdata !== 32'hDEAD_BEEF)
            begin errs++; $display("FAIL wr_mem got gnt=%b we=%b a=%h d=%h exp 1 1 002 deadbeef", bus.ld_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        @(negedge clk);
        idle();
        bus.f_req = 1'b1; bus.f_pc = 32'h3008;
        #1;
        cmps++; if (bus.ld_rvalid !== 1'b0 || bus.ld_fault !== 1'b0)
            begin errs++; $display("FAIL wr_no_rsp got rv=%b f=%b exp 0 0", bus.ld_rvalid, bus.ld_fault); end
        @(negedge clk);
        idle();
        #1;
        cmps++; if (bus.f_valid !== 1'b1 || bus.f_instr !== 32'hDEAD_BEEF || bus.f_fault !== 1'b0)
            begin errs++; $display("FAIL wr_then_fetch got v=%b %h f=%b exp 1 deadbeef 0", bus.f_valid, bus.f_instr, bus.f_fault); end
    endtask

    // Fetch wins only on cycles 4 and 9 when both request continuously
    task automatic test_arbitration();
        logic exp_f, prev_f;
        prev_f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.f_req = 1'b1; bus.f_pc = 32'h3004;
            bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h3000;
            #1;
            exp_f = (i == 4) || (i == 9);
            cmps++; if (bus.f_gnt !== exp_f || bus.ld_gnt !== !exp_f || bus.f_stall !== !exp_f)
                begin errs++; $display("FAIL arb_c%0d got fg=%b lg=%b st=%b exp fg=%b", i, bus.f_gnt, bus.ld_gnt, bus.f_stall, exp_f); end
            if (i > 0) begin
                cmps++;
                if (prev_f) begin
                    if (bus.f_valid !== 1'b1 || bus.ld_rvalid !== 1'b0 || bus.f_instr !== 32'h2222_2222)
                        begin errs++; $display("FAIL arb_rsp%0d got fv=%b lv=%b %h exp fetch 22222222", i, bus.f_valid, bus.ld_rvalid, bus.f_instr); end
                end else begin
                    if (bus.ld_rvalid !== 1'b1 || bus.f_valid !== 1'b0 || bus.ld_rdata !== 32'h1111_1111)
                        begin errs++; $display("FAIL arb_rsp%0d got fv=%b lv=%b %h exp load 11111111", i, bus.f_valid, bus.ld_rvalid, bus.ld_rdata); end
                end
            end
            prev_f = exp_f;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_fault();
        logic [31:0] pcs [3];
        pcs[0] = 32'h2FFC; pcs[1] = 32'h7000; pcs[2] = 32'h3002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            if (i < 3) begin bus.f_req = 1'b1; bus.f_pc = pcs[i]; end
            #1;
            if (i < 3) begin
                cmps++; if (bus.mem_en !== 1'b0 || bus.f_gnt !== 1'b1)
                    begin errs++; $display("FAIL fault_req%0d got en=%b gnt=%b exp 0 1", i, bus.mem_en, bus.f_gnt); end
            end
            if (i > 0) begin
                cmps++; if (bus.f_valid !== 1'b1 || bus.f_fault !== 1'b1 || bus.f_instr !== 32'h0)
                    begin errs++; $display("FAIL fault_rsp%0d got v=%b f=%b %h exp 1 1 0", i - 1, bus.f_valid, bus.f_fault, bus.f_instr); end
            end
        end
        @(negedge clk);
        idle();
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h2000; bus.ld_wdata = 32'h1234_5678;
        #1;
        cmps++; if (bus.mem_en !== 1'b0 || bus.ld_gnt !== 1'b1)
            begin errs++; $display("FAIL ldwr_fault_req got en=%b gnt=%b exp 0 1", bus.mem_en, bus.ld_gnt); end
        @(negedge clk);
        idle();
        #1;
        cmps++; if (bus.ld_fault !== 1'b1 || bus.ld_rvalid !== 1'b0)
            begin errs++; $display("FAIL ldwr_fault_rsp got f=%b rv=%b exp 1 0", bus.ld_fault, bus.ld_rvalid); end
    endtask

    task automatic test_last_word();
        ld_write(32'h6FFC, 32'hA5A5_5A5A);
        @(negedge clk);
        idle();
        bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h6FFC;
        #1;
        cmps++; if (bus.mem_addr !== 12'hFFF || bus.mem_en !== 1'b1)
            begin errs++; $display("FAIL last_addr got %h en=%b exp fff 1", bus.mem_addr, bus.mem_en); end
        @(negedge clk);
        idle();
        #1;
        cmps++; if (bus.ld_rvalid !== 1'b1 || bus.ld_fault !== 1'b0 || bus.ld_rdata !== 32'hA5A5_5A5A)
            begin errs++; $display("FAIL last_data got rv=%b f=%b %h exp 1 0 a5a55a5a", bus.ld_rvalid, bus.ld_fault, bus.ld_rdata); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_pc = 32'h3000;
        bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h3004;
        repeat (4) @(posedge clk);
        #1;
        cmps++; if (bus.f_gnt !== 1'b1) begin errs++; $display("FAIL rst_pre_fgnt got %b exp 1", bus.f_gnt); end
        reset_n = 1'b0;
        #1;
        cmps++; if (bus.f_valid !== 1'b0 || bus.ld_rvalid !== 1'b0)
            begin errs++; $display("FAIL rst_drop got fv=%b lv=%b exp 0 0", bus.f_valid, bus.ld_rvalid); end
        @(negedge clk);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        cmps++; if (bus.f_valid !== 1'b0 || bus.ld_rvalid !== 1'b0)
            begin errs++; $display("FAIL rst_release got fv=%b lv=%b exp 0 0", bus.f_valid, bus.ld_rvalid); end
        // A cleared loader run gives four loader grants before the fetch gets through
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.f_req = 1'b1; bus.f_pc = 32'h3000;
            bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h3004;
            #1;
            cmps++; if (bus.f_gnt !== (i == 4))
                begin errs++; $display("FAIL rst_run_c%0d got fg=%b exp %b", i, bus.f_gnt, (i == 4)); end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_fetch();
        test_write_fetch();
        test_arbitration();
        test_fault();
        test_last_word();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
